// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the MEM-stage access controller and the AXI bridge.
// The controller is the master; the bridge (or a bench responder) is the slave.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check, store lane steering,
// and a single outstanding SRAM-like transaction that stalls the pipeline until done.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_wen_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              pipe_stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       word_data_o,
  output logic              word_valid_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       word_q;

  logic [1:0]        size_eff;
  logic              misaligned;
  logic              addr_err;
  logic              start;
  logic              kill;
  logic              capture;
  logic [31:0]       wdata_al;
  logic [3:0]        wstrb_al;

  // Size 3 is illegal and behaves exactly like a word access, including on the bus.
  assign size_eff = (mem_size_i == 2'd3) ? 2'd2 : mem_size_i;

  always_comb begin
    misaligned = 1'b0;
    case (size_eff)
      2'd1:    misaligned = mem_addr_i[0];
      2'd2:    misaligned = |mem_addr_i[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign addr_err   = (state_q == S_IDLE) && mem_en_i && misaligned;
  assign adel_o     = addr_err && !mem_wen_i;
  assign ades_o     = addr_err && mem_wen_i;
  assign badvaddr_o = addr_err ? mem_addr_i : '0;
  assign start      = (state_q == S_IDLE) && mem_en_i && !misaligned && !flush_i;

  // A flush arriving in the same cycle as the response kills it just like an earlier one.
  assign kill = cancel_q || flush_i;

  always_comb begin
    wdata_al = mem_wdata_i;
    wstrb_al = 4'b1111;
    case (size_eff)
      2'd0: begin
        wdata_al = {4{mem_wdata_i[7:0]}};
        wstrb_al = 4'b0001 << mem_addr_i[1:0];
      end
      2'd1: begin
        wdata_al = {2{mem_wdata_i[15:0]}};
        wstrb_al = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: wstrb_al = 4'b1111;
    endcase
    if (!mem_wen_i) wstrb_al = 4'b0000;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (flush_i) cancel_d = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            capture  = !wr_q && !kill;
            state_d  = kill ? S_IDLE : S_DONE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) cancel_d = 1'b1;
        if (bus.data_data_ok) begin
          capture  = !wr_q && !kill;
          state_d  = kill ? S_IDLE : S_DONE;
          cancel_d = 1'b0;
        end
      end
      S_DONE: begin
        if (flush_i || !pipe_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the reset is asynchronous and clears all state immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      addr_q   <= '0;
      size_q   <= 2'd0;
      wr_q     <= 1'b0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      word_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (start) begin
        addr_q  <= mem_addr_i;
        size_q  <= size_eff;
        wr_q    <= mem_wen_i;
        wdata_q <= wdata_al;
        wstrb_q <= wstrb_al;
      end
      if (capture) word_q <= bus.data_rdata;
    end
  end

  assign bus.data_req   = (state_q == S_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.data_wstrb = wstrb_q;

  assign word_data_o  = word_q;
  assign word_valid_o = (state_q == S_DONE) && !wr_q;
  assign stall_o      = start || (state_q == S_REQ) || (state_q == S_WAIT) || cancel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions checked against a byte-lane arithmetic model of the access rules.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        pipe_stall, flush;
  logic        stall, word_valid, adel, ades;
  logic [31:0] word_data, badvaddr;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en_i     (mem_en),
    .mem_wen_i    (mem_wen),
    .mem_size_i   (mem_size),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .pipe_stall_i (pipe_stall),
    .flush_i      (flush),
    .stall_o      (stall),
    .word_data_o  (word_data),
    .word_valid_o (word_valid),
    .adel_o       (adel),
    .ades_o       (ades),
    .badvaddr_o   (badvaddr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_word;

  // Control outputs observed together: {stall, data_req, word_valid, adel, ades}.
  function automatic logic [4:0] obs();
    return {stall, bus.data_req, word_valid, adel, ades};
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd3) ? 4 : (1 << s);
  endfunction

  function automatic bit is_misaligned(input logic [1:0] s, input logic [31:0] a);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [1:0] exp_size(input logic [1:0] s);
    return 2'($clog2(nbytes(s)));
  endfunction

  function automatic logic [3:0] exp_strb(input bit wen, input logic [1:0] s, input logic [31:0] a);
    if (!wen) return 4'h0;
    return 4'(((1 << nbytes(s)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] b, h;
    b = {24'h0, w[7:0]};
    h = {16'h0, w[15:0]};
    case (nbytes(s))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_en = 1'b0; mem_wen = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    pipe_stall = 1'b0; flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
  endtask

  task automatic test_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 5'b0) $display("FAIL %s_ctrl: got %b want 00000", tag, obs());
    else n_pass++;
    n_checks++;
    if ({bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata, bus.data_wstrb} !== 71'h0)
      $display("FAIL %s_bus: got wr=%b size=%0d addr=%h wdata=%h strb=%b want all 0", tag,
               bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata, bus.data_wstrb);
    else n_pass++;
    n_checks++;
    if ({word_data, badvaddr} !== 64'h0)
      $display("FAIL %s_data: got word_data=%h badvaddr=%h want 0", tag, word_data, badvaddr);
    else n_pass++;
    exp_word = 32'h0;
  endtask

  // One legal access. ak_dly: REQ cycles before the addr_ok cycle; dk_dly: WAIT cycles
  // up to and including data_ok (0 = same cycle as addr_ok); hold: DONE cycles with pipe_stall.
  task automatic do_txn(input string tag, input bit wen, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ak_dly, input int dk_dly, input int hold);
    logic [70:0] e_bus;
    logic [4:0]  e_done;
    e_bus  = {wen, exp_size(size), addr, exp_strb(wen, size, addr), 32'h0};
    e_done = {1'b0, 1'b0, !wen, 1'b0, 1'b0};

    @(negedge clk);
    mem_en = 1'b1; mem_wen = wen; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    pipe_stall = 1'b0; flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
    #1;
    n_checks++;
    if (obs() !== 5'b10000 || word_data !== exp_word)
      $display("FAIL %s_t0: got ctl=%b word=%h want ctl=10000 word=%h", tag, obs(), word_data, exp_word);
    else n_pass++;

    for (int c = 0; c <= ak_dly; c++) begin
      @(negedge clk);
      mem_addr = $urandom; mem_wdata = $urandom;
      bus.data_addr_ok = (c == ak_dly);
      bus.data_data_ok = (c == ak_dly) && (dk_dly == 0);
      bus.data_rdata   = bus.data_data_ok ? rdata : $urandom;
      #1;
      n_checks++;
      if (obs() !== 5'b11000 ||
          {bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb, 32'h0} !== e_bus ||
          (wen && bus.data_wdata !== exp_wdata(size, wdata)))
        $display("FAIL %s_req%0d: got ctl=%b wr=%b size=%0d addr=%h strb=%b wdata=%h want ctl=11000 bus=%h wdata=%h",
                 tag, c, obs(), bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb,
                 bus.data_wdata, e_bus[70:32], exp_wdata(size, wdata));
      else n_pass++;
    end

    for (int c = 1; c <= dk_dly; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = (c == dk_dly);
      bus.data_rdata   = bus.data_data_ok ? rdata : $urandom;
      #1;
      n_checks++;
      if (obs() !== 5'b10000) $display("FAIL %s_wait%0d: got ctl=%b want 10000", tag, c, obs());
      else n_pass++;
    end
    if (!wen) exp_word = rdata;

    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
      pipe_stall = (c < hold);
      #1;
      n_checks++;
      if (obs() !== e_done || word_data !== exp_word)
        $display("FAIL %s_done%0d: got ctl=%b word=%h want ctl=%b word=%h", tag, c, obs(), word_data,
                 e_done, exp_word);
      else n_pass++;
    end

    // Pipeline advances; a stray data_ok in IDLE must not touch word_data.
    @(negedge clk);
    mem_en = 1'b0; pipe_stall = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = $urandom;
    #1;
    n_checks++;
    if (obs() !== 5'b00000) $display("FAIL %s_idle: got ctl=%b want 00000", tag, obs());
    else n_pass++;
  endtask

  task automatic do_err(input string tag, input bit wen, input logic [1:0] size, input logic [31:0] addr);
    logic [4:0] e_ctl;
    e_ctl = {3'b000, !wen, wen};
    @(negedge clk);
    mem_en = 1'b1; mem_wen = wen; mem_size = size; mem_addr = addr; mem_wdata = $urandom;
    pipe_stall = 1'b0; flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    #1;
    n_checks++;
    if (obs() !== e_ctl || badvaddr !== addr)
      $display("FAIL %s_err: got ctl=%b badvaddr=%h want ctl=%b badvaddr=%h", tag, obs(), badvaddr, e_ctl, addr);
    else n_pass++;
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b00000) $display("FAIL %s_noreq: got ctl=%b want 00000", tag, obs());
    else n_pass++;
  endtask

  task automatic test_directed_load();
    do_txn("lw_plan", 1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
  endtask

  task automatic test_store_align();
    do_txn("sb", 1'b1, 2'd0, 32'h0000_2003, 32'h1234_5678, 32'h0, 0, 1, 0);
    do_txn("sh", 1'b1, 2'd1, 32'h0000_2002, 32'h1234_5678, 32'h0, 1, 0, 0);
    do_txn("sz3", 1'b1, 2'd3, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
  endtask

  task automatic test_addr_err();
    do_err("lh", 1'b0, 2'd1, 32'h0000_1001);
    do_err("sw", 1'b1, 2'd2, 32'h0000_1002);
  endtask

  task automatic test_handshake();
    do_txn("aok_hold", 1'b1, 2'd2, 32'h0000_3000, 32'h0BAD_F00D, 32'h0, 5, 1, 0);
    do_txn("same_cyc", 1'b0, 2'd2, 32'h0000_3004, 32'h0, 32'h1357_9BDF, 0, 0, 0);
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    prior = exp_word;
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_4000; flush = 1'b1;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b00000) $display("FAIL flush_idle: got ctl=%b want 00000", obs());
    else n_pass++;
    @(negedge clk);
    flush = 1'b0; mem_en = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b00000) $display("FAIL flush_idle_noreq: got ctl=%b want 00000", obs());
    else n_pass++;

    @(negedge clk);
    mem_en = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0; flush = 1'b1; mem_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        flush = 1'b0;
        bus.data_data_ok = (c == 2);
        bus.data_rdata   = 32'hAAAA_5555;
      end
      #1;
      n_checks++;
      if (obs() !== 5'b10000) $display("FAIL flush_wait%0d: got ctl=%b want 10000", c, obs());
      else n_pass++;
    end
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b00000 || word_data !== prior)
      $display("FAIL flush_after: got ctl=%b word=%h want ctl=00000 word=%h", obs(), word_data, prior);
    else n_pass++;
    do_txn("post_flush", 1'b0, 2'd0, 32'h0000_4001, 32'h0, 32'h0102_0304, 0, 1, 0);
  endtask

  task automatic test_done_hold();
    do_txn("done_hold", 1'b0, 2'd1, 32'h0000_5002, 32'h0, 32'h7777_8888, 1, 2, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_6000;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b10000) $display("FAIL rstmid_wait: got ctl=%b want 10000", obs());
    else n_pass++;
    test_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit          wen;
      logic [1:0]  size;
      logic [31:0] addr;
      wen  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'(nbytes(size) - 1);
      if (is_misaligned(size, addr))
        do_err($sformatf("rnd%0d", i), wen, size, addr);
      else
        do_txn($sformatf("rnd%0d", i), wen, size, addr, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    test_directed_load();
    test_store_align();
    test_addr_err();
    test_handshake();
    test_flush();
    test_done_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
